// File: rtl/eight_window_monitor_if.sv
// Report/control bundle between the gate-stage consumer logic and the window monitor.
// The master side drives the sampled level and the controls; the monitor is the slave.
interface eight_window_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             eight_in;
  logic             start;
  logic             abort;
  logic             busy;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] rise_cnt;
  logic             ovf;

  modport master (
    output eight_in, start, abort, rpt_ready,
    input  busy, rpt_valid, high_cnt, rise_cnt, ovf
  );

  modport slave (
    input  eight_in, start, abort, rpt_ready,
    output busy, rpt_valid, high_cnt, rise_cnt, ovf
  );
endinterface

// File: rtl/eight_window_monitor.sv
// Registers the gate-stage "eight" level and measures high cycles and rising edges
// over a fixed window, then offers the result on a valid/ready report.
module eight_window_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eight_window_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      WIN_LAST = 16'(WIN_LEN - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             eight_q_r;
  logic             eight_qq_r;
  logic [15:0]      win_cnt_r;
  logic [CNT_W-1:0] high_cnt_r;
  logic [CNT_W-1:0] rise_cnt_r;
  logic             ovf_r;
  logic             busy_r;
  logic             rpt_valid_r;
  logic             load_s;
  logic             meas_s;
  logic             rise_s;
  logic [CNT_W-1:0] high_nxt_s;
  logic [CNT_W-1:0] rise_nxt_s;
  logic             ovf_nxt_s;

  // Next-state decode; abort outranks the handshake and the window end.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    meas_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mon.start) begin
          state_nxt_s = ST_MEAS;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (mon.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          meas_s = 1'b1;
          if (win_cnt_r == 16'd0) begin
            state_nxt_s = ST_REPORT;
          end else begin
            state_nxt_s = ST_MEAS;
          end
        end
      end
      ST_REPORT: begin
        if (mon.abort || mon.rpt_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Saturating increments; a blocked increment marks the window as overflowed.
  always_comb begin
    rise_s     = eight_q_r & ~eight_qq_r;
    high_nxt_s = high_cnt_r;
    rise_nxt_s = rise_cnt_r;
    ovf_nxt_s  = ovf_r;
    if (eight_q_r) begin
      if (high_cnt_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        high_nxt_s = high_cnt_r + CNT_ONE;
      end
    end else begin
      high_nxt_s = high_cnt_r;
    end
    if (rise_s) begin
      if (rise_cnt_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        rise_nxt_s = rise_cnt_r + CNT_ONE;
      end
    end else begin
      rise_nxt_s = rise_cnt_r;
    end
  end

  // State, input history, window counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      eight_q_r   <= 1'b0;
      eight_qq_r  <= 1'b0;
      win_cnt_r   <= 16'd0;
      high_cnt_r  <= '0;
      rise_cnt_r  <= '0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      rpt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      eight_q_r   <= mon.eight_in;
      eight_qq_r  <= eight_q_r;
      busy_r      <= (state_nxt_s != ST_IDLE);
      rpt_valid_r <= (state_nxt_s == ST_REPORT);
      if (load_s) begin
        win_cnt_r  <= WIN_LAST;
        high_cnt_r <= '0;
        rise_cnt_r <= '0;
        ovf_r      <= 1'b0;
      end else if (meas_s) begin
        high_cnt_r <= high_nxt_s;
        rise_cnt_r <= rise_nxt_s;
        ovf_r      <= ovf_nxt_s;
        if (win_cnt_r != 16'd0) begin
          win_cnt_r <= win_cnt_r - 16'd1;
        end else begin
          win_cnt_r <= win_cnt_r;
        end
      end else begin
        win_cnt_r <= win_cnt_r;
      end
    end
  end

  assign mon.busy      = busy_r;
  assign mon.rpt_valid = rpt_valid_r;
  assign mon.high_cnt  = high_cnt_r;
  assign mon.rise_cnt  = rise_cnt_r;
  assign mon.ovf       = ovf_r;

endmodule

// File: tb/tb_eight_window_monitor.sv
// Directed bench for eight_window_monitor: a per-cycle vector table on a short-window
// instance plus hand-written sequences on the default and narrow-counter instances.
module tb_eight_window_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  eight_window_monitor_if #(.CNT_W(8)) ifa ();
  eight_window_monitor_if #(.CNT_W(4)) ifb ();
  eight_window_monitor_if #(.CNT_W(8)) ifc ();

  eight_window_monitor #(.CNT_W(8), .WIN_LEN(16)) dut_a (.clk(clk), .rst_n(rst_n), .mon(ifa));
  eight_window_monitor #(.CNT_W(4), .WIN_LEN(20)) dut_b (.clk(clk), .rst_n(rst_n), .mon(ifb));
  eight_window_monitor #(.CNT_W(8), .WIN_LEN(3))  dut_c (.clk(clk), .rst_n(rst_n), .mon(ifc));

  typedef struct {
    logic       eight_in;
    logic       start;
    logic       abort;
    logic       rpt_ready;
    logic       busy;
    logic       valid;
    logic [7:0] high;
    logic [7:0] rise;
    logic       ovf;
  } vec_t;

  vec_t vt[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Steps until the selected instance raises rpt_valid; n counts cycles since the start edge.
  task automatic wait_valid(input bit sel_b, output int n);
    n = 1;
    while (!(sel_b ? ifb.rpt_valid : ifa.rpt_valid) && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start_a();
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
  endtask

  task automatic accept_a(input string name);
    ifa.rpt_ready = 1'b1;
    step();
    ifa.rpt_ready = 1'b0;
    chk(name, {ifa.busy, ifa.rpt_valid}, 2'b00);
  endtask

  initial begin
    int n;
    int vcount;
    ifa.eight_in = 1'b0; ifa.start = 1'b0; ifa.abort = 1'b0; ifa.rpt_ready = 1'b0;
    ifb.eight_in = 1'b0; ifb.start = 1'b0; ifb.abort = 1'b0; ifb.rpt_ready = 1'b0;
    ifc.eight_in = 1'b0; ifc.start = 1'b0; ifc.abort = 1'b0; ifc.rpt_ready = 1'b0;

    // {in, start, abort, ready} -> {busy, valid, high, rise, ovf} after the edge
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0};

    // Reset holds everything at zero even with start and eight_in high
    ifa.eight_in = 1'b1;
    ifa.start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_cycle%0d", i),
          {ifa.busy, ifa.rpt_valid, ifa.ovf, ifa.high_cnt, ifa.rise_cnt}, 19'd0);
    end
    ifa.start    = 1'b0;
    ifa.eight_in = 1'b0;
    rst_n        = 1'b1;
    step();
    chk("reset_no_meas", {ifa.busy, ifa.rpt_valid}, 2'b00);

    for (int i = 0; i < 16; i++) begin
      ifc.eight_in  = vt[i].eight_in;
      ifc.start     = vt[i].start;
      ifc.abort     = vt[i].abort;
      ifc.rpt_ready = vt[i].rpt_ready;
      step();
      chk($sformatf("table_row%0d", i),
          {ifc.busy, ifc.rpt_valid, ifc.ovf, ifc.high_cnt, ifc.rise_cnt},
          {vt[i].busy, vt[i].valid, vt[i].ovf, vt[i].high, vt[i].rise});
    end
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.rpt_ready = 1'b0;

    // Constant-high window
    ifa.eight_in = 1'b1;
    repeat (20) step();
    pulse_start_a();
    wait_valid(1'b0, n);
    chk("const_latency", n, 17);
    chk("const_counts", {ifa.ovf, ifa.high_cnt, ifa.rise_cnt}, {1'b0, 8'd16, 8'd0});
    accept_a("const_accept");

    // Toggling input, eight_q low in the first measured cycle
    ifa.eight_in = 1'b1;
    step();
    ifa.eight_in = 1'b0;
    pulse_start_a();
    n = 1;
    while (!ifa.rpt_valid && n < 60) begin
      ifa.eight_in = ~ifa.eight_in;
      step();
      n++;
    end
    chk("toggle_latency", n, 17);
    chk("toggle_counts", {ifa.ovf, ifa.high_cnt, ifa.rise_cnt}, {1'b0, 8'd8, 8'd8});
    accept_a("toggle_accept");

    // Narrow counter saturates over a 20-cycle window
    ifb.eight_in = 1'b1;
    repeat (3) step();
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    wait_valid(1'b1, n);
    chk("sat_latency", n, 21);
    chk("sat_counts", {ifb.ovf, ifb.high_cnt, ifb.rise_cnt}, {1'b1, 4'd15, 4'd0});
    ifb.rpt_ready = 1'b1;
    step();
    ifb.rpt_ready = 1'b0;
    chk("sat_accept", {ifb.busy, ifb.rpt_valid}, 2'b00);

    // Back-pressure in REPORT with a stray start
    ifa.eight_in = 1'b1;
    repeat (3) step();
    pulse_start_a();
    wait_valid(1'b0, n);
    chk("bp_latency", n, 17);
    for (int k = 0; k < 5; k++) begin
      ifa.start = (k == 1) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("bp_hold%0d", k),
          {ifa.busy, ifa.rpt_valid, ifa.ovf, ifa.high_cnt, ifa.rise_cnt},
          {1'b1, 1'b1, 1'b0, 8'd16, 8'd0});
    end
    ifa.start = 1'b0;
    accept_a("bp_accept");
    step();
    chk("bp_no_queue", {ifa.busy, ifa.high_cnt}, {1'b0, 8'd16});

    // Abort five cycles into the window
    pulse_start_a();
    repeat (4) step();
    chk("abort_busy_before", ifa.busy, 1'b1);
    ifa.abort = 1'b1;
    step();
    ifa.abort = 1'b0;
    chk("abort_idle", {ifa.busy, ifa.rpt_valid}, 2'b00);
    chk("abort_hold_high", ifa.high_cnt, 8'd4);
    vcount = 0;
    repeat (20) begin
      step();
      if (ifa.rpt_valid || ifa.busy) vcount++;
    end
    chk("abort_no_report", vcount, 0);

    // Reset five cycles into the window
    pulse_start_a();
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_idle", {ifa.busy, ifa.rpt_valid, ifa.high_cnt}, {1'b0, 1'b0, 8'd0});
    vcount = 0;
    repeat (20) begin
      step();
      if (ifa.rpt_valid || ifa.busy) vcount++;
    end
    chk("rst_no_report", vcount, 0);

    // Fresh window after abort and reset
    pulse_start_a();
    wait_valid(1'b0, n);
    chk("fresh_latency", n, 17);
    chk("fresh_counts", {ifa.ovf, ifa.high_cnt, ifa.rise_cnt}, {1'b0, 8'd16, 8'd0});
    accept_a("fresh_accept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
